// File: rtl/serial_par_rx.sv
// Receive-side serial-to-parallel lane: hunts for the comma byte, locks the byte
// boundary after COMMA_COUNT aligned commas, then strobes out non-comma bytes.
module serial_par_rx #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det
);

    localparam logic [3:0] COMMA_TARGET = 4'(COMMA_COUNT);

    typedef enum logic [1:0] {
        SEEK,
        ALIGN,
        ACTIVE
    } state_t;

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_comma_cnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_active;
    logic       r_comma_det;

    state_t     w_state_nxt;
    logic [7:0] w_nsr;
    logic       w_byte_done;
    logic [3:0] w_cnt_inc;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] w_comma_cnt_nxt;
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;
    logic       w_active_nxt;
    logic       w_comma_det_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_nsr           = {r_sr[6:0], data_in};
        w_byte_done     = (r_bit_cnt == 3'd7);
        w_cnt_inc       = r_comma_cnt + 4'd1;
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
        w_comma_cnt_nxt = r_comma_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_active_nxt    = r_active;
        w_comma_det_nxt = 1'b0;

        case (r_state)
            SEEK: begin
                // Sliding search: a comma may start on any bit.
                if (w_nsr == COMMA) begin
                    w_comma_det_nxt = 1'b1;
                    w_bit_cnt_nxt   = 3'd0;
                    w_comma_cnt_nxt = 4'd1;
                    if (COMMA_TARGET == 4'd1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (w_byte_done) begin
                    if (w_nsr == COMMA) begin
                        w_comma_det_nxt = 1'b1;
                        w_comma_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == COMMA_TARGET) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt     = SEEK;
                        w_comma_cnt_nxt = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                // Commas are idle fill here: flagged but never delivered.
                if (w_byte_done) begin
                    if (w_nsr == COMMA) begin
                        w_comma_det_nxt = 1'b1;
                    end else begin
                        w_data_nxt  = w_nsr;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = SEEK;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= SEEK;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_comma_det <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_nsr;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_active    <= w_active_nxt;
            r_comma_det <= w_comma_det_nxt;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign active    = r_active;
    assign comma_det = r_comma_det;

endmodule

// File: tb/tb_serial_par_rx.sv
// Self-checking bench for serial_par_rx: directed scenarios plus random traffic,
// every edge compared against a bit-history reference model.
module tb_serial_par_rx;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         CC    = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       comma_det;

    serial_par_rx #(.COMMA(COMMA), .COMMA_COUNT(CC)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .comma_det (comma_det)
    );

    always #5 clk_32f = ~clk_32f;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: full bit history since reset, boundary defined by the
    // absolute index of the comma that first matched.
    logic       hist[$];
    int         n_bits;
    bit         m_aligned;
    int         m_anchor;
    int         m_commas;
    bit         m_active;
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_cd;
    int         n_valid_seen;
    int         n_cd_seen;

    function automatic logic [7:0] last8();
        logic [7:0] w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int idx = hist.size() - 8 + i;
            w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        n_bits    = 0;
        m_aligned = 0;
        m_anchor  = 0;
        m_commas  = 0;
        m_active  = 0;
        m_data    = 8'h00;
        m_valid   = 0;
        m_cd      = 0;
    endtask

    task automatic model_step(input logic b);
        logic [7:0] w;
        hist.push_back(b);
        n_bits++;
        m_valid = 0;
        m_cd    = 0;
        w = last8();
        if (!m_aligned) begin
            if (w == COMMA) begin
                m_cd      = 1;
                m_aligned = 1;
                m_anchor  = n_bits;
                m_commas  = 1;
                if (m_commas >= CC) m_active = 1;
            end
        end else if ((n_bits - m_anchor) % 8 == 0) begin
            if (w == COMMA) begin
                m_cd = 1;
                if (!m_active) begin
                    m_commas++;
                    if (m_commas == CC) m_active = 1;
                end
            end else if (m_active) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_aligned = 0;
                m_commas  = 0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".valid"},  32'(valid_out), 32'(m_valid));
        check({where, ".data"},   32'(data_out),  32'(m_data));
        check({where, ".active"}, 32'(active),    32'(m_active));
        check({where, ".cdet"},   32'(comma_det), 32'(m_cd));
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(b);
        if (valid_out) n_valid_seen++;
        if (comma_det) n_cd_seen++;
        compare_all("edge");
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("rst.data",   32'(data_out),  32'h0);
        check("rst.valid",  32'(valid_out), 32'h0);
        check("rst.active", 32'(active),    32'h0);
        check("rst.cdet",   32'(comma_det), 32'h0);
        model_reset();
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    initial begin
        int v0, c0;
        logic [7:0] rb;
        model_reset();
        n_valid_seen = 0;
        n_cd_seen    = 0;
        #12;
        check("por.active", 32'(active),   32'h0);
        check("por.data",   32'(data_out), 32'h0);
        @(negedge clk_32f);
        reset = 1'b1;

        // Idle zeros: nothing may be detected.
        c0 = n_cd_seen;
        for (int i = 0; i < 64; i++) send_bit(1'b0);
        check("idle.cdet_cnt", 32'(n_cd_seen - c0), 32'd0);

        // Clean alignment then three data bytes.
        v0 = n_valid_seen; c0 = n_cd_seen;
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check("align.active", 32'(active), 32'd1);
        send_byte(8'h5A); send_byte(8'hFF); send_byte(8'h00);
        check("basic.valid_cnt", 32'(n_valid_seen - v0), 32'd3);
        check("basic.cdet_cnt",  32'(n_cd_seen - c0),    32'd4);

        // Alignment at a 3-bit offset.
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_byte(8'h12);
        check("offset.data", 32'(data_out), 32'h12);

        // Broken alignment falls back to SEEK, then realigns.
        do_reset();
        v0 = n_valid_seen;
        send_byte(COMMA); send_byte(COMMA); send_byte(8'h33);
        check("break.active", 32'(active), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_byte(8'h44);
        check("realign.valid_cnt", 32'(n_valid_seen - v0), 32'd1);
        check("realign.data", 32'(data_out), 32'h44);

        // Commas interleaved with data are stripped.
        v0 = n_valid_seen; c0 = n_cd_seen;
        send_byte(8'hA1); send_byte(COMMA); send_byte(COMMA); send_byte(8'hB2);
        check("strip.valid_cnt", 32'(n_valid_seen - v0), 32'd2);
        check("strip.cdet_cnt",  32'(n_cd_seen - c0),    32'd2);
        check("strip.active",    32'(active),            32'd1);

        // Reset mid-byte; fresh commas needed afterwards.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset();
        send_byte(COMMA); send_byte(COMMA); send_byte(COMMA);
        send_byte(8'h77);
        check("postrst.active", 32'(active), 32'd0);

        // Random traffic: garbage, commas, data, occasional resets.
        for (int it = 0; it < 400; it++) begin
            int sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                do_reset();
            end else if (sel < 4) begin
                int nb = int'($urandom_range(1, 7));
                for (int k = 0; k < nb; k++) send_bit(1'($urandom));
            end else if (sel < 10) begin
                send_byte(COMMA);
            end else begin
                rb = 8'($urandom);
                send_byte(rb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_par_rx.md
Name: serial_par_rx

Overview:
- PHY receive-side serial-to-parallel converter. It is the counterpart of the transmit-side parallel-to-serial lane.
- Shifts in one serial bit per clk_32f, MSB first, and hunts for the comma byte to find the byte boundary.
- Declares the lane active after COMMA_COUNT consecutive aligned commas.
- Once active, delivers non-comma bytes on data_out with a one-cycle valid_out strobe, for the downstream un-striping logic.

Parameters:
- COMMA, 8'hBC, idle/alignment character sent by the transmitter while idle.
- COMMA_COUNT, 4, consecutive aligned commas required before active asserts (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received non-comma byte, held between strobes.
- valid_out  output  1  one-cycle strobe marking a new byte on data_out.
- active  output  1  lane aligned and carrying data; sticky until reset.
- comma_det  output  1  one-cycle pulse on each comma detection (seek hit or aligned comma).

Behaviour:
- Reset (reset=0, asynchronous):
  - sr=8'h00, bit_cnt=0, comma_cnt=0, state=SEEK.
  - data_out=8'h00, valid_out=0, active=0, comma_det=0.
  - Applies immediately in any state, including mid-byte; no partial byte survives.
- Every edge out of reset:
  - nsr={sr[6:0],data_in}; sr<=nsr.
  - valid_out and comma_det default to 0 unless set below.
- SEEK (bit-level sliding search):
  - If nsr==COMMA: comma_det<=1, bit_cnt<=0, comma_cnt<=1.
  - Then go to ACTIVE if COMMA_COUNT==1 (also active<=1), else to ALIGN.
  - Otherwise stay in SEEK; bit_cnt is don't-care.
- Byte framing in ALIGN and ACTIVE:
  - bit_cnt counts 0..7. The edge with bit_cnt==7 completes a byte (byte=nsr) and sets bit_cnt<=0; other edges increment bit_cnt.
  - Exactly 8 clk_32f edges separate successive byte completions. bit_cnt is 3 bits and wraps 7->0.
- ALIGN, on byte completion:
  - byte==COMMA: comma_det<=1, comma_cnt<=comma_cnt+1. If comma_cnt+1==COMMA_COUNT: state<=ACTIVE, active<=1 on that same edge.
  - byte!=COMMA: state<=SEEK, comma_cnt<=0, no output. The next search starts from the following bit.
- ACTIVE, on byte completion:
  - byte==COMMA: comma_det<=1, valid_out stays 0, data_out held.
  - byte!=COMMA: data_out<=byte and valid_out<=1 on the same edge.
  - Latency: byte visible on the edge that shifts in its LSB.
  - active never deasserts except by reset.
  - Commas interleaved with data are stripped and do not affect alignment.
- comma_cnt width is 4 bits; it saturates in ACTIVE (not used there).
- Boundary conditions:
  - Because sr resets to 8'h00, no comma can be detected before 8 bits have been shifted after reset release.
  - A comma straddling a false boundary in ALIGN fails the byte check, returns to SEEK and realigns.
  - Data bytes equal to COMMA are never delivered; 8'hBC is reserved.
- Transmitter contract (decided; this block relies on it):
  - The transmitter sends at least COMMA_COUNT commas after its own reset before any data.
  - The transmitter sends a comma whenever it has no valid byte.

Test Plan:
- Reset release, data_in held 0 for 64 cycles -> state SEEK; active, valid_out, comma_det stay 0; data_out=8'h00.
- Send 4×8'hBC, then 8'h5A, 8'hFF, 8'h00 -> comma_det pulses 4 times at 8-cycle spacing. active rises on the 32nd bit edge. valid_out pulses 3 times, 8 cycles apart, with data_out=5A, FF, 00; data_out holds FF between its strobes.
- 3 garbage bits 3'b101, then 4×BC, then 8'h12 -> alignment found at bit offset 3 and active=1. data_out=8'h12 exactly 8 edges after the 4th comma completes.
- Send 2×BC, then 8'h33, then 4×BC, then 8'h44 -> return to SEEK after 33, no valid_out. Realign; active=1; single strobe with 44.
- While active, send A1, BC, BC, B2 -> exactly two strobes (A1, B2) 24 cycles apart; comma_det pulses twice; active stays 1.
- Assert reset at bit 4 of a data byte while active -> all outputs 0 immediately, asynchronously. After release, the receiver requires 4 fresh commas before data is accepted.
